// File: rtl/ysyx_24100012_alu_pkg.sv
// Shared ALU definitions: op-select codes, select width and the arbiter FSM encoding.
package ysyx_24100012_alu_pkg;

  localparam int SEL_WIDTH = 4;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/ysyx_24100012_alu.sv
// Purely combinational ALU; shift amounts are taken unmasked from operand b.
module ysyx_24100012_alu #(
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = ysyx_24100012_alu_pkg::SEL_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [SEL_WIDTH-1:0]  sel,
  output logic [DATA_WIDTH-1:0] result
);
  import ysyx_24100012_alu_pkg::*;

  always_comb begin
    result = '0;
    case (sel)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << b;
      ALU_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: result = {{(DATA_WIDTH-1){1'b0}}, a < b};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> b;
      ALU_SRA:  result = $unsigned($signed(a) >>> b);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      // Unknown codes answer with zero rather than stalling the requester.
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_24100012_alu_arb.sv
// Round-robin arbiter sharing one ALU between EXU (req 0) and the branch-target unit (req 1).
module ysyx_24100012_alu_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = ysyx_24100012_alu_pkg::SEL_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [1:0]                req_valid,
  output logic [1:0]                req_ready,
  input  logic [2*DATA_WIDTH-1:0]   req_a,
  input  logic [2*DATA_WIDTH-1:0]   req_b,
  input  logic [2*SEL_WIDTH-1:0]    req_sel,
  output logic [1:0]                resp_valid,
  input  logic [1:0]                resp_ready,
  output logic [DATA_WIDTH-1:0]     resp_data,
  output logic                      busy
);
  import ysyx_24100012_alu_pkg::*;

  state_t                state;
  logic                  last_grant;
  logic                  owner;
  logic                  grant;
  logic                  accept;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [SEL_WIDTH-1:0]  op_sel;
  logic [DATA_WIDTH-1:0] alu_result;

  always_comb begin
    grant = req_valid[1];
    if (req_valid == 2'b11) grant = ~last_grant;
  end

  // Handshake: a transfer happens on a rising edge where valid[i] & ready[i] are both 1.
  // req_ready is a combinational function of req_valid, state, flush and rst; requesters
  // must not make req_valid depend on req_ready. Responses complete on resp_valid[owner] &
  // resp_ready[owner]; resp_data is stable while resp_valid is high.
  assign req_ready  = (rst && !flush && state == S_IDLE) ?
                      (req_valid & (grant ? 2'b10 : 2'b01)) : 2'b00;
  assign accept     = |req_ready;
  assign resp_valid = (state == S_RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign busy       = (state != S_IDLE);

  ysyx_24100012_alu #(
    .DATA_WIDTH(DATA_WIDTH),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_alu (
    .a     (op_a),
    .b     (op_b),
    .sel   (op_sel),
    .result(alu_result)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      op_sel     <= '0;
      resp_data  <= '0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_a       <= grant ? req_a[DATA_WIDTH +: DATA_WIDTH] : req_a[0 +: DATA_WIDTH];
            op_b       <= grant ? req_b[DATA_WIDTH +: DATA_WIDTH] : req_b[0 +: DATA_WIDTH];
            op_sel     <= grant ? req_sel[SEL_WIDTH +: SEL_WIDTH] : req_sel[0 +: SEL_WIDTH];
            owner      <= grant;
            last_grant <= grant;
            state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          resp_data <= alu_result;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready[owner]) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24100012_alu_arb.sv
// Directed bench for the shared-ALU arbiter: reset, latency, contention, backpressure, flush, op codes.
module tb_ysyx_24100012_alu_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [7:0]  req_sel;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [31:0] resp_data;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  ysyx_24100012_alu_arb dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sel   (req_sel),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data (resp_data),
    .busy      (busy)
  );

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] sel);
    if (i == 0) begin
      req_a[31:0] = a; req_b[31:0] = b; req_sel[3:0] = sel;
    end else begin
      req_a[63:32] = a; req_b[63:32] = b; req_sel[7:4] = sel;
    end
    req_valid[i] = 1'b1;
  endtask

  task automatic test_reset();
    logic [1:0] seen;
    @(negedge clk);
    set_req(0, 32'd1, 32'd2, 4'b0000);
    #1 checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL reset_pre_grant: got %b expected 01", req_ready); end
    @(negedge clk);
    req_valid  = 2'($urandom_range(0, 3));
    req_a      = {$urandom, $urandom};
    req_b      = {$urandom, $urandom};
    req_sel    = 8'($urandom_range(0, 255));
    resp_ready = 2'($urandom_range(0, 3));
    rst = 1'b0;
    #1 checks++;
    if (resp_valid !== 2'b00) begin errors++; $display("FAIL reset_resp_valid: got %b expected 00", resp_valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
    @(negedge clk);
    rst = 1'b1; req_valid = 2'b00; resp_ready = 2'b00;
    #1 checks++;
    if (resp_data !== 32'd0) begin errors++; $display("FAIL reset_resp_data: got %h expected 0", resp_data); end
    seen = 2'b00;
    repeat (4) begin
      @(negedge clk); #1 seen = seen | resp_valid;
    end
    checks++;
    if (seen !== 2'b00) begin errors++; $display("FAIL reset_discard: got resp_valid %b expected 00", seen); end
  endtask

  task automatic test_contention();
    logic [1:0] exp_grant [3];
    exp_grant[0] = 2'b01; exp_grant[1] = 2'b10; exp_grant[2] = 2'b01;
    @(negedge clk);
    set_req(0, 32'd10, 32'd3, 4'b1000);
    set_req(1, 32'h8000_0000, 32'd4, 4'b1101);
    resp_ready = 2'b11;
    for (int k = 0; k < 3; k++) begin
      #1 checks++;
      if (req_ready !== exp_grant[k]) begin
        errors++; $display("FAIL contention_grant%0d: got %b expected %b", k, req_ready, exp_grant[k]);
      end
      exp_q.push_back((k == 1) ? 32'hF800_0000 : 32'd7);
      @(negedge clk);
      if (k == 2) req_valid = 2'b00;
      #1 checks++;
      if (req_ready !== 2'b00) begin errors++; $display("FAIL contention_exec_ready%0d: got %b expected 00", k, req_ready); end
      @(negedge clk);
      #1 checks++;
      if (resp_valid !== exp_grant[k]) begin
        errors++; $display("FAIL contention_resp_valid%0d: got %b expected %b", k, resp_valid, exp_grant[k]);
      end
      checks++;
      if (resp_data !== exp_q[0]) begin
        errors++; $display("FAIL contention_data%0d: got %h expected %h", k, resp_data, exp_q[0]);
      end
      void'(exp_q.pop_front());
      @(negedge clk);
    end
  endtask

  task automatic test_single_op();
    set_req(0, 32'd7, 32'd5, 4'b0000);
    resp_ready = 2'b11;
    #1 checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b expected 01", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    #1 checks++;
    if (resp_valid !== 2'b00 || busy !== 1'b1) begin
      errors++; $display("FAIL single_exec: got resp_valid %b busy %b expected 00 1", resp_valid, busy);
    end
    @(negedge clk);
    #1 checks++;
    if (resp_valid !== 2'b01) begin errors++; $display("FAIL single_resp_valid: got %b expected 01", resp_valid); end
    checks++;
    if (resp_data !== 32'd12) begin errors++; $display("FAIL single_data: got %h expected 0000000c", resp_data); end
    @(negedge clk);
    #1 checks++;
    if (busy !== 1'b0 || resp_valid !== 2'b00) begin
      errors++; $display("FAIL single_idle: got busy %b resp_valid %b expected 0 00", busy, resp_valid);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    set_req(1, 32'd1, 32'd2, 4'b0011);
    resp_ready = 2'b00;
    #1 checks++;
    if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_grant: got %b expected 10", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    req_valid  = 2'b01;
    resp_ready = 2'b01;
    for (int k = 0; k < 5; k++) begin
      #1 checks++;
      if (resp_valid !== 2'b10 || resp_data !== 32'd1 || req_ready !== 2'b00) begin
        errors++;
        $display("FAIL bp_hold%0d: got resp_valid %b data %h req_ready %b expected 10 00000001 00",
                 k, resp_valid, resp_data, req_ready);
      end
      @(negedge clk);
    end
    req_valid  = 2'b00;
    resp_ready = 2'b10;
    #1 checks++;
    if (resp_valid !== 2'b10) begin errors++; $display("FAIL bp_release_cycle: got %b expected 10", resp_valid); end
    @(negedge clk);
    resp_ready = 2'b11;
    #1 checks++;
    if (busy !== 1'b0 || resp_valid !== 2'b00) begin
      errors++; $display("FAIL bp_idle: got busy %b resp_valid %b expected 0 00", busy, resp_valid);
    end
  endtask

  task automatic test_flush();
    logic [1:0] seen;
    @(negedge clk);
    set_req(0, 32'h0000_00FF, 32'h0000_000F, 4'b0100);
    #1 checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL flush_grant: got %b expected 01", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1 checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle: got busy %b expected 0", busy); end
    seen = 2'b00;
    repeat (3) begin
      @(negedge clk); #1 seen = seen | resp_valid;
    end
    checks++;
    if (seen !== 2'b00) begin errors++; $display("FAIL flush_no_resp: got %b expected 00", seen); end
    @(negedge clk);
    flush = 1'b1;
    req_valid = 2'b01;
    #1 checks++;
    if (req_ready !== 2'b00) begin errors++; $display("FAIL flush_blocks_grant: got %b expected 00", req_ready); end
    @(negedge clk);
    flush = 1'b0;
    #1 checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL flush_regrant: got %b expected 01", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    #1 checks++;
    if (resp_valid !== 2'b01 || resp_data !== 32'h0000_00F0) begin
      errors++; $display("FAIL flush_next_op: got %b %h expected 01 000000f0", resp_valid, resp_data);
    end
    @(negedge clk);
  endtask

  task automatic test_alu_codes();
    int          who [6];
    logic [31:0] va  [6];
    logic [31:0] vb  [6];
    logic [3:0]  vs  [6];
    logic [31:0] ve  [6];
    logic [1:0]  oh;
    who[0] = 1; va[0] = 32'd5;         vb[0] = 32'd6;      vs[0] = 4'b1111; ve[0] = 32'd0;
    who[1] = 0; va[1] = 32'hFFFF_FFFF; vb[1] = 32'd1;      vs[1] = 4'b0010; ve[1] = 32'd1;
    who[2] = 1; va[2] = 32'd1;         vb[2] = 32'd31;     vs[2] = 4'b0001; ve[2] = 32'h8000_0000;
    who[3] = 0; va[3] = 32'h8000_0000; vb[3] = 32'd4;      vs[3] = 4'b0101; ve[3] = 32'h0800_0000;
    who[4] = 1; va[4] = 32'h0000_F0F0; vb[4] = 32'h0000_FF00; vs[4] = 4'b0111; ve[4] = 32'h0000_F000;
    who[5] = 0; va[5] = 32'd1;         vb[5] = 32'd32;     vs[5] = 4'b0001; ve[5] = 32'd0;
    for (int k = 0; k < 6; k++) begin
      oh = (who[k] == 1) ? 2'b10 : 2'b01;
      set_req(who[k], va[k], vb[k], vs[k]);
      #1 checks++;
      if (req_ready !== oh) begin errors++; $display("FAIL alu_grant%0d: got %b expected %b", k, req_ready, oh); end
      @(negedge clk);
      req_valid = 2'b00;
      @(negedge clk);
      #1 checks++;
      if (resp_valid !== oh || resp_data !== ve[k]) begin
        errors++;
        $display("FAIL alu_result%0d: got %b %h expected %b %h", k, resp_valid, resp_data, oh, ve[k]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; req_valid = 2'b00; resp_ready = 2'b00;
    req_a = '0; req_b = '0; req_sel = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    test_reset();
    test_contention();
    test_single_op();
    test_backpressure();
    test_flush();
    test_alu_codes();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
